// File: rtl/odd_even_seq_sort_pkg.sv
// Shared types and constants for the sequential odd-even transposition sorter.
package odd_even_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_e;

  localparam bit ASC  = 1'b0;
  localparam bit DESC = 1'b1;

  // Phase counter must be able to hold 0..N.
  function automatic int unsigned ph_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/odd_even_seq_sort_if.sv
// Producer/consumer handshake bundle for odd_even_seq_sort.
interface odd_even_seq_sort_if #(
  parameter int unsigned N = 10,
  parameter int unsigned W = 4
) ();
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_desc;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic           busy;

  modport master (
    output in_valid, in_data, in_desc, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_desc, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/odd_even_seq_sort_cmp_swap.sv
// Single compare-exchange cell; equal operands never swap, keeping the sort stable.
module oe_cmp_swap
  import odd_even_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic [W-1:0] lo_pos,
  output logic [W-1:0] hi_pos,
  output logic         swapped
);

  logic a_gt_b;
  logic a_lt_b;

  if (SIGNED) begin : g_signed
    assign a_gt_b = $signed(a) > $signed(b);
    assign a_lt_b = $signed(a) < $signed(b);
  end else begin : g_unsigned
    assign a_gt_b = a > b;
    assign a_lt_b = a < b;
  end

  assign swapped = (desc == DESC) ? a_lt_b : a_gt_b;
  assign lo_pos  = swapped ? b : a;
  assign hi_pos  = swapped ? a : b;

endmodule

// File: rtl/odd_even_seq_sort.sv
// Sequential odd-even transposition sorter: one phase per clock over N W-bit elements,
// with a valid/ready handshake on each side.
module odd_even_seq_sort
  import odd_even_pkg::*;
#(
  parameter int unsigned N          = 10,
  parameter int unsigned W          = 4,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input logic               clk,
  input logic               rst,
  odd_even_seq_sort_if.slave bus
);

  localparam int unsigned PW  = ph_width(N);
  localparam int unsigned NE  = N / 2;
  localparam int unsigned NO  = (N - 1) / 2;
  localparam int unsigned NOW = (NO > 0) ? NO : 1;

  // Element 0 sits at the most significant end, matching the bus packing.
  typedef logic [0:N-1][W-1:0] vec_t;

  state_e          state_q, state_d;
  vec_t            e_q, e_d;
  vec_t            even_nxt, odd_nxt;
  logic            desc_q, desc_d;
  logic            swap_q, swap_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [NE-1:0]   even_sw;
  logic [NOW-1:0]  odd_sw;
  logic            any_swap;
  logic            last_phase;
  logic            settled;
  logic            in_ready, out_valid, busy;

  for (genvar k = 0; k < NE; k++) begin : g_even
    oe_cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cs (
      .a       (e_q[2*k]),
      .b       (e_q[2*k+1]),
      .desc    (desc_q),
      .lo_pos  (even_nxt[2*k]),
      .hi_pos  (even_nxt[2*k+1]),
      .swapped (even_sw[k])
    );
  end

  if (N % 2 == 1) begin : g_even_tail
    assign even_nxt[N-1] = e_q[N-1];
  end

  for (genvar k = 0; k < NO; k++) begin : g_odd
    oe_cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cs (
      .a       (e_q[2*k+1]),
      .b       (e_q[2*k+2]),
      .desc    (desc_q),
      .lo_pos  (odd_nxt[2*k+1]),
      .hi_pos  (odd_nxt[2*k+2]),
      .swapped (odd_sw[k])
    );
  end

  assign odd_nxt[0] = e_q[0];

  if (N % 2 == 0) begin : g_odd_tail
    assign odd_nxt[N-1] = e_q[N-1];
  end

  if (NO == 0) begin : g_no_odd
    assign odd_sw = '0;
  end

  assign any_swap   = ph_q[0] ? |odd_sw : |even_sw;
  assign last_phase = (ph_q == PW'(N - 1));
  // Two consecutive quiet phases (ending on an odd one) prove the vector is ordered.
  assign settled    = EARLY_EXIT && ph_q[0] && !any_swap && !swap_q;

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    desc_d    = desc_q;
    swap_d    = swap_q;
    ph_d      = ph_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          e_d     = bus.in_data;
          desc_d  = bus.in_desc;
          ph_d    = '0;
          swap_d  = 1'b0;
          state_d = SORT;
        end
      end
      SORT: begin
        busy   = 1'b1;
        e_d    = ph_q[0] ? odd_nxt : even_nxt;
        swap_d = any_swap;
        ph_d   = ph_q + PW'(1);
        if (last_phase || settled) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            e_d     = bus.in_data;
            desc_d  = bus.in_desc;
            ph_d    = '0;
            swap_d  = 1'b0;
            state_d = SORT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      e_q     <= '0;
      desc_q  <= 1'b0;
      swap_q  <= 1'b0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      desc_q  <= desc_d;
      swap_q  <= swap_d;
      ph_q    <= ph_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.out_data  = e_q;

endmodule
